y_demux_tdm: RTL
================

# y_demux_tdm

Registered time-division demultiplexer: the receive side of the 2:1 select datapath (`yMux1` family). A single muxed stream arrives one word per accepted beat, framed by a start-of-frame marker. The block steers each word to its channel register and presents a complete parallel frame to downstream logic under a valid/acknowledge handshake. It sits between a serial link or bus and the parallel consumers that the mux side fed from.

## Interface
- `WIDTH`, 1, bits per channel word
- `CHANNELS`, 4, channels per frame, ≥2
- `clk` input 1, rising-edge clock
- `rst_n` input 1, asynchronous active-low reset
- `in_valid` input 1, input word present
- `in_data` input WIDTH, muxed input word
- `in_sof` input 1, qualifies `in_data` as channel 0 (start of frame); meaningful only with `in_valid`
- `in_ready` output 1, block can accept a word this cycle
- `out_data` output CHANNELS*WIDTH, channel k at bits [k*WIDTH +: WIDTH]
- `out_valid` output CHANNELS, per-channel written flag for the current frame
- `frame_valid` output 1, complete frame held
- `out_ack` input 1, consumer releases held frame
- `sync_err` output 1, one-cycle pulse on framing violation

## Operation
- Beat accepted when `in_valid && in_ready` at a rising edge.
- States:
  - IDLE: waiting for a frame start. Accepted word with `in_sof` writes channel 0, sets counter = 1, goes to RUN. Accepted word without `in_sof` is dropped and pulses `sync_err`.
  - RUN: accepted word without `in_sof` writes channel[counter] and sets its `out_valid` bit. Counter increments. The word for channel CHANNELS-1 goes to HOLD.
  - HOLD: `in_ready`=0. `frame_valid`=1. `out_ack` clears `out_valid` and `frame_valid` and returns to IDLE.
- `in_ready` = 1 in IDLE and RUN, 0 in HOLD (registered state decode, no combinational path from `out_ack`).
- Resync: an accepted `in_sof` while in RUN pulses `sync_err` and clears all `out_valid` bits. That word is written to channel 0 with only `out_valid[0]` set, and the counter goes to 1. State stays RUN.
- `out_ack` outside HOLD is ignored.
- `out_data` is not cleared by `out_ack`; it holds until overwritten. Only `out_valid` is authoritative.
- Counter width is clog2(CHANNELS). The counter never wraps; the HOLD transition happens at CHANNELS-1.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, `out_data`=0, `out_valid`=0, `frame_valid`=0, `sync_err`=0, `in_ready`=1.
- Write latency: 1 cycle. Word accepted at edge N is visible on `out_data` / `out_valid` after edge N.
- `frame_valid` rises at the same edge that writes the last channel. A back-to-back stream therefore takes CHANNELS cycles from the sof beat to `frame_valid`.
- Ack at edge M: `frame_valid` and `out_valid` are 0 after M, and `in_ready`=1 after M. The next sof is accepted no earlier than edge M+1.
- `sync_err` is high for exactly the one cycle after the offending edge.
- `rst_n` low mid-frame or in HOLD: everything returns to reset values immediately and the partial frame is discarded.

## Structure
- Package `y_tdm_pkg` holds:
  - state enum {IDLE, RUN, HOLD}
  - a clog2-based counter-width function
- Sub-module `y_chan_decode` (combinational, 1-to-CHANNELS one-hot write-enable from counter + accept) is the demux counterpart of `yMux1`. It is unit-tested standalone.

## Test plan
- WIDTH=8, CHANNELS=4: send sof+0xA1, 0xB2, 0xC3, 0xD4 back-to-back
  - `frame_valid` after 4th edge
  - `out_data`=0xD4C3B2A1, `out_valid`=4'b1111
  - `in_ready`=0 until ack, then IDLE
- Word 0x55 with `in_sof`=0 in IDLE -> dropped, one-cycle `sync_err`, `out_valid`=0, state IDLE.
- sof+0x11, 0x22, then sof+0x33 -> `sync_err` pulse, `out_valid`=4'b0001, channel 0=0x33. Then 0x44, 0x55, 0x66 complete the frame with `out_data`=0x66554433.
- In HOLD, hold `in_valid` high with sof+0x77 for 3 cycles without ack -> word not accepted, outputs stable. Assert ack -> word accepted on the cycle after ack.
- Assert `rst_n` low after 2 words -> all outputs 0 asynchronously. After release, a fresh full frame completes normally.
- `in_valid` gaps: sof+0x01, idle 2 cycles, 0x02, idle, 0x03, 0x04 -> `frame_valid` only after 0x04, `out_data`=0x04030201.

Source files
------------

// File: rtl/y_tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// Holds the frame FSM state encoding and the channel-counter width rule.
package y_tdm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   // A counter that can name every channel; never narrower than one bit.
   function automatic int cnt_width(input int channels);
      return (channels > 2) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/y_chan_decode.sv
// One-hot channel write-enable decoder: the demux counterpart of yMux1.
// Purely combinational; drives exactly one enable when en_i is high.
module y_chan_decode
   import y_tdm_pkg::*;
#(
   parameter int CHANNELS = 4,
   localparam int CW = cnt_width(CHANNELS)
) (
   input  logic [CW-1:0]       sel_i,
   input  logic                en_i,
   output logic [CHANNELS-1:0] we_o
);

   always_comb begin
      // NOTE: default every output first so no path can infer a latch.
      we_o = '0;
      if (en_i) we_o[sel_i] = 1'b1;
   end

endmodule

// File: rtl/y_demux_tdm.sv
// Registered TDM demultiplexer: steers a framed muxed word stream into
// per-channel registers and holds each complete frame until acknowledged.
module y_demux_tdm
   import y_tdm_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_sof,
   output logic                      in_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   output logic                      frame_valid,
   input  logic                      out_ack,
   output logic                      sync_err
);

   localparam int CW = cnt_width(CHANNELS);
   localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CHANNELS-1:0] valid_q, valid_d;
   logic                sync_err_q, sync_err_d;
   logic [WIDTH-1:0]    data_q [CHANNELS];

   logic                accept;
   logic                wr_en;
   logic [CW-1:0]       wr_sel;
   logic [CHANNELS-1:0] we;

   assign accept = in_valid && in_ready;
   // An sof always targets channel 0; plain words only land while in RUN.
   assign wr_en  = accept && (in_sof || (state_q == RUN));
   assign wr_sel = in_sof ? '0 : cnt_q;

   y_chan_decode #(.CHANNELS(CHANNELS)) u_decode (
      .sel_i (wr_sel),
      .en_i  (wr_en),
      .we_o  (we)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept && in_sof) state_d = RUN;
         RUN:     if (accept && !in_sof && (cnt_q == LAST)) state_d = HOLD;
         HOLD:    if (out_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (state_q != HOLD);
      frame_valid = (state_q == HOLD);
   end

   always_comb begin
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      sync_err_d = 1'b0;
      if (accept) begin
         if (in_sof) begin
            cnt_d      = CW'(1);
            valid_d    = we;
            sync_err_d = (state_q == RUN);
         end else if (state_q == RUN) begin
            cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
            valid_d = valid_q | we;
         end else begin
            sync_err_d = 1'b1;
         end
      end
      if ((state_q == HOLD) && out_ack) begin
         cnt_d   = '0;
         valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         valid_q    <= '0;
         sync_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         sync_err_q <= sync_err_d;
      end
   end

   // NOTE: channel registers are reset too, because out_data must read zero
   // after reset rather than stale contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CHANNELS; k++) data_q[k] <= '0;
      end else begin
         for (int k = 0; k < CHANNELS; k++)
            if (we[k]) data_q[k] <= in_data;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_out
      assign out_data[k*WIDTH +: WIDTH] = data_q[k];
   end

   assign out_valid = valid_q;
   assign sync_err  = sync_err_q;

endmodule
